tri_assembler: RTL and testbench

Downstream of the vertex generator, this block regroups the generator's interleaved vertex stream into whole triangles, one per object, and attaches each triangle's colour. It buffers finished triangles in a small FIFO and presents them to the rasterizer over a ready/valid handshake. The vertex generator has no backpressure input, so this block is where flow control begins; FIFO overflow is detected and reported, never silently absorbed.

---
 rtl/threed_pkg.sv | 24 ++
 rtl/tri_fifo.sv | 54 +++++
 rtl/tri_assembler.sv | 114 +++++++++++
 tb/tb_tri_assembler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/threed_pkg.sv
// Shared types and widths for the triangle assembly path.
package threed_pkg;

  localparam int VTX_W   = 96;
  localparam int TRI_W   = 288;
  localparam int COLOR_W = 24;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
  } vertex_t;

  typedef enum logic [1:0] {
    VA = 2'd0,
    VB = 2'd1,
    VC = 2'd2
  } vsel_e;

  function automatic vsel_e vsel_next(input vsel_e v);
    return (v == VC) ? VA : vsel_e'(v + 2'd1);
  endfunction

endpackage

// File: rtl/tri_fifo.sv
// First-word-fall-through FIFO: the head entry is visible on dout whenever not empty.
module tri_fifo #(
  parameter int WIDTH = 313,
  parameter int DEPTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the output is gated to zero while empty
  // instead, so stale or uninitialised contents are never visible.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/tri_assembler.sv
// Regroups the object-interleaved vertex stream into per-object triangles and
// queues them for the rasterizer behind a ready/valid handshake.
module tri_assembler
  import threed_pkg::*;
#(
  parameter int OBJS       = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               vtx_valid_in,
  input  logic [31:0]        vtx_x_in,
  input  logic [31:0]        vtx_y_in,
  input  logic [31:0]        vtx_z_in,
  input  logic [COLOR_W-1:0] vtx_color_in,
  input  logic               vtx_last_in,
  output logic               tri_valid_out,
  input  logic               tri_ready_in,
  output logic [TRI_W-1:0]   tri_data_out,
  output logic [COLOR_W-1:0] tri_color_out,
  output logic               tri_last_out,
  output logic               overflow_out,
  output logic               sync_err_out
);

  localparam int OBJ_W   = (OBJS > 1) ? $clog2(OBJS) : 1;
  localparam int ENTRY_W = TRI_W + COLOR_W + 1;
  localparam logic [OBJ_W-1:0] OBJ_MAX = OBJ_W'(OBJS - 1);

  logic [OBJ_W-1:0]   obj_cnt;
  vsel_e              vsel;
  vertex_t            bank_a [OBJS];
  vertex_t            bank_b [OBJS];
  vertex_t            cur_vtx;
  logic               group_end, misaligned, c_strobe;
  logic               asm_valid;
  logic [ENTRY_W-1:0] asm_entry;
  logic               fifo_full, fifo_empty, fifo_pop;
  logic [ENTRY_W-1:0] fifo_dout;

  assign cur_vtx    = {vtx_x_in, vtx_y_in, vtx_z_in};
  assign group_end  = (obj_cnt == OBJ_MAX) && (vsel == VC);
  assign misaligned = vtx_valid_in && vtx_last_in && !group_end;
  assign c_strobe   = vtx_valid_in && (vsel == VC);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      obj_cnt      <= '0;
      vsel         <= VA;
      sync_err_out <= 1'b0;
      for (int i = 0; i < OBJS; i++) begin
        bank_a[i] <= '0;
        bank_b[i] <= '0;
      end
    end else if (vtx_valid_in) begin
      if (vsel == VA) bank_a[obj_cnt] <= cur_vtx;
      if (vsel == VB) bank_b[obj_cnt] <= cur_vtx;
      if (misaligned) begin
        // NOTE: the later non-blocking clear overrides the bank write above for
        // the same element, so a misaligned last vertex discards everything.
        obj_cnt      <= '0;
        vsel         <= VA;
        sync_err_out <= 1'b1;
        for (int i = 0; i < OBJS; i++) begin
          bank_a[i] <= '0;
          bank_b[i] <= '0;
        end
      end else if (obj_cnt == OBJ_MAX) begin
        obj_cnt <= '0;
        vsel    <= vsel_next(vsel);
      end else begin
        obj_cnt <= obj_cnt + 1'b1;
      end
    end
  end

  // The C vertex completes its object's triangle; its last flag rides along,
  // so a misaligned C vertex still emits a triangle marked last.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      asm_valid <= 1'b0;
      asm_entry <= '0;
    end else begin
      asm_valid <= c_strobe;
      if (c_strobe)
        asm_entry <= {bank_a[obj_cnt], bank_b[obj_cnt], cur_vtx, vtx_color_in, vtx_last_in};
    end
  end

  assign fifo_pop = tri_valid_out && tri_ready_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                                  overflow_out <= 1'b0;
    else if (asm_valid && fifo_full && !fifo_pop)   overflow_out <= 1'b1;
  end

  tri_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .push     (asm_valid),
    .pop      (fifo_pop),
    .din      (asm_entry),
    .dout     (fifo_dout),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign tri_valid_out = !fifo_empty;
  assign {tri_data_out, tri_color_out, tri_last_out} = fifo_dout;

endmodule

// File: tb/tb_tri_assembler.sv
// Scoreboard bench: stimulus predicts triangles from a group-list model, a
// negedge monitor compares every presented head against the expected queue.
module tb_tri_assembler;
  import threed_pkg::*;

  localparam int OBJS    = 2;
  localparam int DEPTH   = 8;
  localparam int ENTRY_W = TRI_W + COLOR_W + 1;

  logic               clk_in = 1'b0;
  logic               rst_n_in = 1'b0;
  logic               vtx_valid_in = 1'b0;
  logic [31:0]        vtx_x_in = '0, vtx_y_in = '0, vtx_z_in = '0;
  logic [COLOR_W-1:0] vtx_color_in = '0;
  logic               vtx_last_in = 1'b0;
  logic               tri_valid_out;
  logic               tri_ready_in = 1'b1;
  logic [TRI_W-1:0]   tri_data_out;
  logic [COLOR_W-1:0] tri_color_out;
  logic               tri_last_out;
  logic               overflow_out;
  logic               sync_err_out;

  always #5 clk_in = ~clk_in;

  tri_assembler #(.OBJS(OBJS), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .vtx_valid_in  (vtx_valid_in),
    .vtx_x_in      (vtx_x_in),
    .vtx_y_in      (vtx_y_in),
    .vtx_z_in      (vtx_z_in),
    .vtx_color_in  (vtx_color_in),
    .vtx_last_in   (vtx_last_in),
    .tri_valid_out (tri_valid_out),
    .tri_ready_in  (tri_ready_in),
    .tri_data_out  (tri_data_out),
    .tri_color_out (tri_color_out),
    .tri_last_out  (tri_last_out),
    .overflow_out  (overflow_out),
    .sync_err_out  (sync_err_out)
  );

  logic [ENTRY_W-1:0] exp_q[$];
  vertex_t            grp[$];
  int                 total = 0, bad = 0, popped = 0;
  logic               exp_ovf = 1'b0, exp_sync = 1'b0;

  task automatic check(input string name, input logic [ENTRY_W-1:0] act,
                       input logic [ENTRY_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: a group is 3*OBJS vertices in order A(o..), B(o..), C(o..).
  task automatic model_vertex(input vertex_t v, input logic [COLOR_W-1:0] col, input logic last);
    int n, obj;
    grp.push_back(v);
    n   = grp.size();
    obj = (n - 1) % OBJS;
    if ((n - 1) / OBJS == 2) begin
      if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
      else exp_q.push_back({grp[obj], grp[OBJS + obj], v, col, last});
    end
    if (last && n != 3 * OBJS) exp_sync = 1'b1;
    if (last || n == 3 * OBJS) grp.delete();
  endtask

  task automatic send(input logic last);
    vertex_t v;
    logic [COLOR_W-1:0] col;
    v   = {$urandom, $urandom, $urandom};
    col = COLOR_W'($urandom);
    model_vertex(v, col, last);
    {vtx_x_in, vtx_y_in, vtx_z_in} = v;
    vtx_color_in = col;
    vtx_last_in  = last;
    vtx_valid_in = 1'b1;
    @(posedge clk_in); #1;
    vtx_valid_in = 1'b0;
    vtx_last_in  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_in); #1; end
  endtask

  task automatic drain(input string name);
    int i;
    tri_ready_in = 1'b1;
    idle(3);
    i = 0;
    while ((exp_q.size() != 0 || tri_valid_out) && i < 300) begin
      idle(1);
      i++;
    end
    check({name, "_queue_empty"}, ENTRY_W'(exp_q.size()), '0);
    check({name, "_valid_low"}, ENTRY_W'(tri_valid_out), '0);
  endtask

  always @(negedge clk_in) begin
    if (rst_n_in && tri_valid_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_tri_valid", ENTRY_W'(tri_valid_out), '0);
      end else begin
        check("tri_head", {tri_data_out, tri_color_out, tri_last_out}, exp_q[0]);
        if (tri_ready_in) begin
          void'(exp_q.pop_front());
          popped++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ENTRY_W-1:0] held;
    int base;

    // Reset state
    #1;
    check("rst_outputs", ENTRY_W'({tri_valid_out, tri_last_out, overflow_out, sync_err_out}), '0);
    check("rst_data", {tri_data_out, tri_color_out, tri_last_out}, '0);
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    idle(1);

    // One group back-to-back, ready high, plus latency of the first triangle
    tri_ready_in = 1'b1;
    repeat (4) send(1'b0);
    send(1'b0);
    check("lat_after_c0_edge", ENTRY_W'(tri_valid_out), '0);
    send(1'b0);
    check("lat_one_edge_later", ENTRY_W'(tri_valid_out), 1);
    drain("group1");

    // Full frame: 12 positions x 2 objects, last on the final vertex
    base = popped;
    for (int i = 0; i < 72; i++) send(i == 71);
    drain("frame");
    check("frame_tri_count", ENTRY_W'(popped - base), 24);
    check("frame_sync_err", ENTRY_W'(sync_err_out), '0);

    // Ready low throughout: 8 retained, 9th dropped
    tri_ready_in = 1'b0;
    for (int i = 1; i <= 72; i++) begin
      send(i == 72);
      if (i == 29) check("ovf_before_drop", ENTRY_W'(overflow_out), '0);
      if (i == 30) check("ovf_at_drop", ENTRY_W'(overflow_out), 1);
    end
    idle(3);
    check("ovf_sticky", ENTRY_W'(overflow_out), ENTRY_W'(exp_ovf));
    check("ovf_retained", ENTRY_W'(exp_q.size()), DEPTH);
    base = popped;
    drain("ovf_drain");
    check("ovf_drain_count", ENTRY_W'(popped - base), DEPTH);

    // Misaligned last on B1: no triangle, sticky error, then a clean group
    repeat (3) send(1'b0);
    send(1'b1);
    idle(4);
    check("sync_err_set", ENTRY_W'(sync_err_out), ENTRY_W'(exp_sync));
    check("sync_no_tri", ENTRY_W'(tri_valid_out), '0);
    base = popped;
    repeat (6) send(1'b0);
    drain("resync");
    check("resync_count", ENTRY_W'(popped - base), 2);

    // Stall with 3 queued: head held, then 3 pops on consecutive cycles
    tri_ready_in = 1'b0;
    repeat (11) send(1'b0);
    idle(3);
    held = {tri_data_out, tri_color_out, tri_last_out};
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("stall_hold", {tri_data_out, tri_color_out, tri_last_out}, held);
    end
    tri_ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      check("release_pop_valid", ENTRY_W'(tri_valid_out), 1);
    end
    @(negedge clk_in);
    check("release_empty", ENTRY_W'(tri_valid_out), '0);
    @(posedge clk_in); #1;
    send(1'b0);
    drain("stall");

    // Random traffic, throttled so the FIFO can never fill
    for (int i = 0; i < 400; i++) begin
      tri_ready_in = 1'($urandom_range(0, 1));
      if (exp_q.size() < DEPTH - 3 && $urandom_range(0, 9) < 7)
        send($urandom_range(0, 15) == 0);
      else
        idle(1);
    end
    drain("random");
    check("random_sync_err", ENTRY_W'(sync_err_out), ENTRY_W'(exp_sync));
    check("random_ovf", ENTRY_W'(overflow_out), ENTRY_W'(exp_ovf));

    // Asynchronous reset mid-group with triangles queued and flags set
    tri_ready_in = 1'b0;
    repeat (6) send(1'b0);
    repeat (3) send(1'b0);
    send(1'b1);
    repeat (3) send(1'b0);
    idle(2);
    check("pre_rst_valid", ENTRY_W'(tri_valid_out), 1);
    check("pre_rst_flags", ENTRY_W'({overflow_out, sync_err_out}), 2'b11);
    #2;
    rst_n_in = 1'b0;
    exp_q.delete();
    grp.delete();
    exp_ovf  = 1'b0;
    exp_sync = 1'b0;
    #1;
    check("async_rst_outputs", ENTRY_W'({tri_valid_out, tri_last_out, overflow_out, sync_err_out}), '0);
    check("async_rst_data", {tri_data_out, tri_color_out, tri_last_out}, '0);
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    tri_ready_in = 1'b1;
    base = popped;
    repeat (6) send(1'b0);
    drain("post_rst");
    check("post_rst_count", ENTRY_W'(popped - base), 2);
    check("post_rst_flags", ENTRY_W'({overflow_out, sync_err_out}), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
